// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and output-side bus of the shared mux arbiter.
interface rr_mux_arbiter_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = 3,
    parameter int unsigned DW   = 8
);
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] in_data;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic [SELW-1:0] sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;

    modport master (
        output req, last, in_data, out_ready,
        input  grant, sel, out_valid, out_data, out_last
    );

    modport slave (
        input  req, last, in_data, out_ready,
        output grant, sel, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin priority scan: first set request after ptr, wrapping, ptr itself last.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 8,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic            o_any,
    output logic [SELW-1:0] o_idx
);

    logic [SELW-1:0] w_cand;

    // N is a power of two, so SELW-bit addition wraps modulo N.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_cand = i_ptr + SELW'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared N:1 word mux and streams
// the granted requester's beats, bounded by last or MAXHOLD beats per grant.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned SELW    = 3,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_mux_arbiter_if.slave bus
);

    localparam int unsigned CNTW = $clog2(MAXHOLD) + 1;

    if (!is_pow2(N) || (N < 2) || (N > 16)) begin : g_chk_n
        $error("rr_mux_arbiter: N must be a power of two in 2..16");
    end
    if (SELW != sel_width(N)) begin : g_chk_selw
        $error("rr_mux_arbiter: SELW must equal log2(N)");
    end
    if (MAXHOLD < 1) begin : g_chk_hold
        $error("rr_mux_arbiter: MAXHOLD must be at least 1");
    end

    state_e          r_state;
    logic [N-1:0]    r_grant;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;
    logic [CNTW-1:0] r_count;

    state_e          w_nxt_state;
    logic [N-1:0]    w_nxt_grant;
    logic [SELW-1:0] w_nxt_sel;
    logic [SELW-1:0] w_nxt_ptr;
    logic [CNTW-1:0] w_nxt_count;

    logic            w_busy;
    logic            w_valid;
    logic            w_at_max;
    logic            w_last;
    logic            w_xfer;
    logic            w_release;
    logic [SELW-1:0] w_pick_ptr;
    logic            w_pick_any;
    logic [SELW-1:0] w_pick_idx;
    logic [N-1:0]    w_pick_onehot;

    assign w_busy    = (r_state == BUSY);
    assign w_valid   = w_busy & bus.req[r_sel];
    assign w_at_max  = (r_count == CNTW'(MAXHOLD - 1));
    assign w_last    = w_valid & (bus.last[r_sel] | w_at_max);
    assign w_xfer    = w_valid & bus.out_ready;
    assign w_release = (w_xfer & w_last) | ~w_valid;

    // In BUSY the pick only matters on release, where ptr becomes sel.
    assign w_pick_ptr    = w_busy ? r_sel : r_ptr;
    assign w_pick_onehot = N'(1) << w_pick_idx;

    rr_pick #(.N(N)) u_pick (
        .i_req (bus.req),
        .i_ptr (w_pick_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= SELW'(N - 1);
            r_count <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_count <= w_nxt_count;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_nxt_count = r_count;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_nxt_state = BUSY;
                    w_nxt_sel   = w_pick_idx;
                    w_nxt_grant = w_pick_onehot;
                    w_nxt_count = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_nxt_ptr   = r_sel;
                    w_nxt_count = '0;
                    if (w_pick_any) begin
                        w_nxt_sel   = w_pick_idx;
                        w_nxt_grant = w_pick_onehot;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_grant = '0;
                    end
                end else if (w_xfer) begin
                    w_nxt_count = r_count + CNTW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = bus.in_data[r_sel*DW +: DW];
    assign bus.out_last  = w_last;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N=8, DW=8, MAXHOLD=4).
module tb_rr_mux_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_mux_arbiter_if #(.N(8), .SELW(3), .DW(8)) bus ();

    rr_mux_arbiter #(.N(8), .SELW(3), .DW(8), .MAXHOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] word(input int i);
        return 8'(i * 17);
    endfunction

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.req       = '0;
        bus.last      = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = word(i);

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_last", 32'(bus.out_last), 32'h0);
        chk("rst_ptr", 32'(dut.r_ptr), 32'h7);

        // Reset priority: 0 wins over 7, 4-beat cap, then 7 with no gap
        rst           = 1'b0;
        bus.req       = 8'h81;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_valid", 32'(bus.out_valid), 32'h0);
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk($sformatf("rp_grant_b%0d", b), 32'(bus.grant), 32'h01);
            chk($sformatf("rp_valid_b%0d", b), 32'(bus.out_valid), 32'h1);
            chk($sformatf("rp_last_b%0d", b), 32'(bus.out_last), (b == 4) ? 32'h1 : 32'h0);
            chk($sformatf("rp_data_b%0d", b), 32'(bus.out_data), 32'h00);
        end
        tick();
        chk("rp_grant7", 32'(bus.grant), 32'h80);
        chk("rp_sel7", 32'(bus.sel), 32'h7);
        chk("rp_valid7", 32'(bus.out_valid), 32'h1);

        // Fair rotation: single-beat grants cycling 0..7,0
        bus.req  = 8'hFF;
        bus.last = 8'hFF;
        #1;
        chk("fr_last7", 32'(bus.out_last), 32'h1);
        chk("fr_data7", 32'(bus.out_data), 32'h77);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("fr_sel_%0d", i), 32'(bus.sel), 32'(i % 8));
            chk($sformatf("fr_grant_%0d", i), 32'(bus.grant), 32'(1 << (i % 8)));
            chk($sformatf("fr_data_%0d", i), 32'(bus.out_data), 32'(word(i % 8)));
            chk($sformatf("fr_last_%0d", i), 32'(bus.out_last), 32'h1);
        end

        // Backpressure on requester 3
        bus.req = 8'h00;
        tick();
        chk("bp_idle", 32'(bus.grant), 32'h0);
        bus.in_data[3*8 +: 8] = 8'hA5;
        bus.req       = 8'h08;
        bus.last      = 8'h08;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_grant_%0d", c), 32'(bus.grant), 32'h08);
            chk($sformatf("bp_sel_%0d", c), 32'(bus.sel), 32'h3);
            chk($sformatf("bp_valid_%0d", c), 32'(bus.out_valid), 32'h1);
            chk($sformatf("bp_count_%0d", c), 32'(dut.r_count), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_data", 32'(bus.out_data), 32'hA5);
        chk("bp_xlast", 32'(bus.out_last), 32'h1);
        tick();
        chk("bp_ptr", 32'(dut.r_ptr), 32'h3);
        chk("bp_regrant", 32'(bus.grant), 32'h08);
        bus.req = 8'h00;
        tick();
        chk("bp_done", 32'(bus.grant), 32'h0);

        // Abandon: requester 2 drops after one beat while 5 waits
        bus.req  = 8'h04;
        bus.last = 8'h00;
        tick();
        chk("ab_grant2", 32'(bus.grant), 32'h04);
        bus.req = 8'h24;
        #1;
        chk("ab_nopreempt_valid", 32'(bus.out_valid), 32'h1);
        tick();
        chk("ab_hold2", 32'(bus.grant), 32'h04);
        chk("ab_count1", 32'(dut.r_count), 32'h1);
        bus.req = 8'h20;
        #1;
        chk("ab_drop_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("ab_grant5", 32'(bus.grant), 32'h20);
        chk("ab_sel5", 32'(bus.sel), 32'h5);
        chk("ab_ptr2", 32'(dut.r_ptr), 32'h2);
        chk("ab_count0", 32'(dut.r_count), 32'h0);
        bus.req = 8'h00;
        tick();
        chk("ab_idle", 32'(bus.grant), 32'h0);

        // Sole requester 6: ten beats split 4,4,2 with no bubble
        bus.req = 8'h40;
        for (int b = 1; b <= 10; b++) begin
            tick();
            bus.last = (b == 10) ? 8'h40 : 8'h00;
            #1;
            chk($sformatf("so_grant_b%0d", b), 32'(bus.grant), 32'h40);
            chk($sformatf("so_valid_b%0d", b), 32'(bus.out_valid), 32'h1);
            chk($sformatf("so_count_b%0d", b), 32'(dut.r_count), 32'((b - 1) % 4));
            chk($sformatf("so_last_b%0d", b), 32'(bus.out_last),
                (b == 4 || b == 8 || b == 10) ? 32'h1 : 32'h0);
        end
        tick();
        bus.req  = 8'h00;
        bus.last = 8'h00;
        #1;
        chk("so_tail_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("so_idle_grant", 32'(bus.grant), 32'h0);
        chk("so_idle_state", 32'(dut.r_state), 32'h0);

        // Mid-burst reset
        bus.req = 8'h01;
        tick();
        chk("mr_grant0", 32'(bus.grant), 32'h01);
        tick();
        chk("mr_count1", 32'(dut.r_count), 32'h1);
        rst = 1'b1;
        tick();
        chk("mr_grant", 32'(bus.grant), 32'h0);
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_sel", 32'(bus.sel), 32'h0);
        chk("mr_ptr", 32'(dut.r_ptr), 32'h7);
        rst     = 1'b0;
        bus.req = 8'h81;
        tick();
        chk("mr_regrant0", 32'(bus.grant), 32'h01);
        chk("mr_resel0", 32'(bus.sel), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
